// File: rtl/int_logic_fu.sv
// Multi-cycle OR/AND/XOR/SUB functional unit with issue and write-back handshakes, one op in flight.
// Optional result flags (wb_zero, wb_neg) are enabled by defining INT_LOGIC_FU_FLAGS_EN.
module int_logic_fu #(
  parameter int unsigned W       = 16,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_op,
  input  logic [W-1:0]     issue_a,
  input  logic [W-1:0]     issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             flush,
  output logic             busy,
  output logic             wb_valid,
  input  logic             wb_ack,
  output logic [W-1:0]     wb_result,
  output logic [TAG_W-1:0] wb_tag
`ifdef INT_LOGIC_FU_FLAGS_EN
  ,
  output logic             wb_zero,
  output logic             wb_neg
`endif
);

  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       result_q, result_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [W-1:0]       alu_res;
  logic               accept;

  always_comb begin
    alu_res = '0;
    unique case (issue_op)
      2'b00:   alu_res = issue_a | issue_b;
      2'b01:   alu_res = issue_a & issue_b;
      2'b10:   alu_res = issue_a ^ issue_b;
      default: alu_res = issue_a - issue_b;
    endcase
  end

  assign issue_ready = (state_q == S_IDLE) && !flush;
  assign accept      = issue_valid && issue_ready;
  assign busy        = (state_q != S_IDLE);
  assign wb_valid    = (state_q == S_DONE);
  assign wb_result   = result_q;
  assign wb_tag      = tag_q;

  // Flush overrides every transition, including an ack in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    tag_d    = tag_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d  = (LATENCY == 1) ? S_DONE : S_EXEC;
            cnt_d    = CNT_INIT;
            result_d = alu_res;
            tag_d    = issue_tag;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_DONE: begin
          if (wb_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

`ifdef INT_LOGIC_FU_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (accept) begin
      zero_d = (alu_res == '0);
      neg_d  = alu_res[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign wb_zero = zero_q;
  assign wb_neg  = neg_q;
`endif

endmodule

// File: tb/tb_int_logic_fu.sv
// Bench for int_logic_fu: three instances (LATENCY 2, 1, 4) driven by a vector table,
// hand-written flush/reset sequences and random ops checked against a reference model.
module tb_int_logic_fu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  iv, rdy, fl, bsy, wbv, ack;
  logic [1:0]  op  [3];
  logic [15:0] a   [3];
  logic [15:0] b   [3];
  logic [15:0] res [3];
  logic [4:0]  tg  [3];
  logic [4:0]  wtg [3];
`ifdef INT_LOGIC_FU_FLAGS_EN
  logic [2:0]  wz, wn;
`endif

  int total  = 0;
  int passed = 0;

  int_logic_fu #(.W(16), .TAG_W(5), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv[0]), .issue_ready(rdy[0]),
    .issue_op(op[0]), .issue_a(a[0]), .issue_b(b[0]), .issue_tag(tg[0]),
    .flush(fl[0]), .busy(bsy[0]), .wb_valid(wbv[0]), .wb_ack(ack[0]),
    .wb_result(res[0]), .wb_tag(wtg[0])
`ifdef INT_LOGIC_FU_FLAGS_EN
    , .wb_zero(wz[0]), .wb_neg(wn[0])
`endif
  );

  int_logic_fu #(.W(16), .TAG_W(5), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv[1]), .issue_ready(rdy[1]),
    .issue_op(op[1]), .issue_a(a[1]), .issue_b(b[1]), .issue_tag(tg[1]),
    .flush(fl[1]), .busy(bsy[1]), .wb_valid(wbv[1]), .wb_ack(ack[1]),
    .wb_result(res[1]), .wb_tag(wtg[1])
`ifdef INT_LOGIC_FU_FLAGS_EN
    , .wb_zero(wz[1]), .wb_neg(wn[1])
`endif
  );

  int_logic_fu #(.W(16), .TAG_W(5), .LATENCY(4)) u2 (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv[2]), .issue_ready(rdy[2]),
    .issue_op(op[2]), .issue_a(a[2]), .issue_b(b[2]), .issue_tag(tg[2]),
    .flush(fl[2]), .busy(bsy[2]), .wb_valid(wbv[2]), .wb_ack(ack[2]),
    .wb_result(res[2]), .wb_tag(wtg[2])
`ifdef INT_LOGIC_FU_FLAGS_EN
    , .wb_zero(wz[2]), .wb_neg(wn[2])
`endif
  );

  typedef struct {
    int          d;
    logic [1:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  t;
    logic [15:0] e;
    int          hold;
  } vec_t;

  vec_t vec [10];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic logic [15:0] ref_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int unsigned xi, yi;
    xi = x;
    yi = y;
    case (o)
      2'd0:    return x | y;
      2'd1:    return x & y;
      2'd2:    return x ^ y;
      default: return 16'((xi + 32'd65536 - yi) % 32'd65536);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency, optionally stall the ack while pestering with a second issue.
  task automatic run_op(input int d, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [4:0] t, input logic [15:0] e, input int hold, input string name);
    int n;
    chk({name, ":ready"}, 32'(rdy[d]), 32'd1);
    op[d] = o; a[d] = x; b[d] = y; tg[d] = t; iv[d] = 1'b1;
    step();
    iv[d] = 1'b0;
    n = 1;
    while (!wbv[d] && n < 20) begin
      step();
      n++;
    end
    chk({name, ":latency"}, 32'(n), 32'(lat_of(d)));
    chk({name, ":result"}, 32'(res[d]), 32'(e));
    chk({name, ":tag"}, 32'(wtg[d]), 32'(t));
`ifdef INT_LOGIC_FU_FLAGS_EN
    chk({name, ":zero"}, 32'(wz[d]), 32'(e == 16'd0));
    chk({name, ":neg"}, 32'(wn[d]), 32'(e[15]));
`endif
    if (hold > 0) begin
      op[d] = ~o; a[d] = ~x; b[d] = y + 16'd1; tg[d] = t + 5'd1; iv[d] = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk({name, ":hold_valid"}, 32'(wbv[d]), 32'd1);
      chk({name, ":hold_result"}, 32'(res[d]), 32'(e));
      chk({name, ":hold_ready"}, 32'(rdy[d]), 32'd0);
    end
    ack[d] = 1'b1;
    step();
    ack[d] = 1'b0;
    iv[d]  = 1'b0;
    #1;
    chk({name, ":ack_valid"}, 32'(wbv[d]), 32'd0);
    chk({name, ":ack_ready"}, 32'(rdy[d]), 32'd1);
    chk({name, ":ack_busy"}, 32'(bsy[d]), 32'd0);
    chk({name, ":ack_result_kept"}, 32'(res[d]), 32'(e));
    chk({name, ":ack_tag_kept"}, 32'(wtg[d]), 32'(t));
  endtask

  initial begin
    int seen, n;
    logic [1:0]  ro;
    logic [15:0] rx, ry;
    logic [4:0]  rt;

    iv = '0; fl = '0; ack = '0;
    for (int d = 0; d < 3; d++) begin
      op[d] = '0; a[d] = '0; b[d] = '0; tg[d] = '0;
    end

    vec[0] = '{0, 2'b00, 16'd8,      16'd6,      5'd3,  16'd14,     0};
    vec[1] = '{0, 2'b11, 16'd8,      16'd6,      5'd4,  16'd2,      0};
    vec[2] = '{0, 2'b11, 16'd6,      16'd8,      5'd5,  16'hFFFE,   5};
    vec[3] = '{0, 2'b01, 16'hF0F0,   16'h0FF0,   5'd7,  16'h00F0,   1};
    vec[4] = '{0, 2'b11, 16'd5,      16'd5,      5'd9,  16'h0000,   0};
    vec[5] = '{1, 2'b10, 16'hF0F0,   16'h0FF0,   5'd1,  16'hFF00,   0};
    vec[6] = '{1, 2'b11, 16'd0,      16'd1,      5'd31, 16'hFFFF,   2};
    vec[7] = '{2, 2'b00, 16'd0,      16'd0,      5'd0,  16'h0000,   0};
    vec[8] = '{2, 2'b01, 16'hFFFF,   16'hFFFF,   5'd12, 16'hFFFF,   1};
    vec[9] = '{2, 2'b10, 16'h1234,   16'h1234,   5'd6,  16'h0000,   0};

    #17 rst_n = 1'b1;
    step();
    for (int d = 0; d < 3; d++) begin
      chk("reset:wb_valid", 32'(wbv[d]), 32'd0);
      chk("reset:busy", 32'(bsy[d]), 32'd0);
      chk("reset:ready", 32'(rdy[d]), 32'd1);
      chk("reset:result", 32'(res[d]), 32'd0);
      chk("reset:tag", 32'(wtg[d]), 32'd0);
`ifdef INT_LOGIC_FU_FLAGS_EN
      chk("reset:zero", 32'(wz[d]), 32'd0);
      chk("reset:neg", 32'(wn[d]), 32'd0);
`endif
    end

    for (int i = 0; i < 10; i++)
      run_op(vec[i].d, vec[i].o, vec[i].x, vec[i].y, vec[i].t, vec[i].e, vec[i].hold,
             $sformatf("vec%0d", i));

    // Flush in EXEC, then flush together with an issue in IDLE.
    op[0] = 2'b00; a[0] = 16'h0011; b[0] = 16'h0100; tg[0] = 5'd2; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    chk("flush:exec_busy", 32'(bsy[0]), 32'd1);
    fl[0] = 1'b1;
    step();
    chk("flush:squashed_valid", 32'(wbv[0]), 32'd0);
    chk("flush:squashed_busy", 32'(bsy[0]), 32'd0);
    iv[0] = 1'b1; a[0] = 16'h7777;
    #1;
    chk("flush:ready_blocked", 32'(rdy[0]), 32'd0);
    step();
    chk("flush:issue_not_taken", 32'(bsy[0]), 32'd0);
    fl[0] = 1'b0; iv[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wbv[0]) seen++;
    end
    chk("flush:no_writeback", 32'(seen), 32'd0);

    // Flush and ack together in DONE.
    op[2] = 2'b11; a[2] = 16'd100; b[2] = 16'd1; tg[2] = 5'd8; iv[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    n = 0;
    while (!wbv[2] && n < 20) begin
      step();
      n++;
    end
    chk("flushack:reached_done", 32'(wbv[2]), 32'd1);
    fl[2] = 1'b1; ack[2] = 1'b1;
    step();
    fl[2] = 1'b0; ack[2] = 1'b0;
    #1;
    chk("flushack:valid", 32'(wbv[2]), 32'd0);
    chk("flushack:busy", 32'(bsy[2]), 32'd0);
    chk("flushack:ready", 32'(rdy[2]), 32'd1);

    // Asynchronous reset while in EXEC.
    op[0] = 2'b00; a[0] = 16'hAAAA; b[0] = 16'h0000; tg[0] = 5'd21; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    chk("rstmid:exec_busy", 32'(bsy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid:valid", 32'(wbv[0]), 32'd0);
    chk("rstmid:busy", 32'(bsy[0]), 32'd0);
    chk("rstmid:result", 32'(res[0]), 32'd0);
    chk("rstmid:tag", 32'(wtg[0]), 32'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wbv[0]) seen++;
    end
    chk("rstmid:no_stale_wb", 32'(seen), 32'd0);
    chk("rstmid:ready", 32'(rdy[0]), 32'd1);

    for (int d = 0; d < 3; d += 2) begin
      for (int i = 0; i < 30; i++) begin
        ro = 2'($urandom_range(0, 3));
        rx = 16'($urandom);
        ry = (i % 7 == 0) ? rx : 16'($urandom);
        rt = 5'($urandom);
        run_op(d, ro, rx, ry, rt, ref_op(ro, rx, ry), int'($urandom_range(0, 3)),
               $sformatf("rnd%0d_%0d", d, i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
